// File: rtl/semaforo_timeout_gen_pkg.sv
// rtl/semaforo_timeout_gen_pkg.sv - shared state encodings and defaults for the traffic-light timeout generator
package semaforo_timeout_gen_pkg;

    typedef logic [1:0] state_t;

    // Encodings match the FSM side of the TIMEOUT link; 2'b11 is unused and recovers to WAIT.
    localparam logic [1:0] ST_WAIT  = 2'b00;
    localparam logic [1:0] ST_COUNT = 2'b01;
    localparam logic [1:0] ST_FIRE  = 2'b10;

    // Defaults shared with the FSM bench.
    localparam int RED_CYCLES_DEF = 4;
    localparam int CNT_W_DEF      = 8;

    // True when exactly one of the three lamps is lit.
    function automatic logic lights_one_hot(input logic grn, input logic ylw, input logic red);
        return (grn ^ ylw ^ red) & ~(grn & ylw & red);
    endfunction

endpackage

// File: rtl/semaforo_timeout_gen_contador_fase.sv
// rtl/semaforo_timeout_gen_contador_fase.sv - dwell counter with sync clear, load-1, increment and terminal-count flag
module contador_fase #(
    parameter int                CNT_W  = 8,
    parameter logic [CNT_W-1:0]  TC_VAL = '1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [CNT_W-1:0] q,
    output logic             tc
);

    // Clear beats load-1 beats increment; no request holds the value.
    always_ff @(posedge clk) begin
        if (res || clr) begin
            q <= '0;
        end else if (load1) begin
            q <= CNT_W'(1);
        end else if (inc) begin
            q <= q + CNT_W'(1);
        end
    end

    // Terminal count: the next RED edge completes the dwell.
    always_comb begin
        tc = (q == TC_VAL);
    end

endmodule

// File: rtl/semaforo_timeout_gen.sv
// rtl/semaforo_timeout_gen.sv - watches the lamps, pulses TIMEOUT after RED dwell, flags non-one-hot lamps
module semaforo_timeout_gen
    import semaforo_timeout_gen_pkg::*;
#(
    parameter int RED_CYCLES = RED_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             GRN,
    input  logic             YLW,
    input  logic             RED,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] ELAPSED,
    output logic             ERR
);

    // The compare at RED_CYCLES-1 must fit the counter, and >=2 keeps the handshake tail pulse-free.
    if (RED_CYCLES < 2 || RED_CYCLES > (2 ** CNT_W)) begin : g_bad_red_cycles
        $error("semaforo_timeout_gen: RED_CYCLES out of range 2..2**CNT_W");
    end

    state_t           state_q;
    state_t           state_d;
    logic             err_q;
    logic             lights_ok;
    logic             cnt_clr;
    logic             cnt_load1;
    logic             cnt_inc;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_q;

    contador_fase #(
        .CNT_W  (CNT_W),
        .TC_VAL (CNT_W'(RED_CYCLES - 1))
    ) u_contador_fase (
        .clk   (clk),
        .res   (res),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .q     (cnt_q),
        .tc    (cnt_tc)
    );

    // Next state and counter commands; a lamp fault (current or latched) parks everything in WAIT.
    always_comb begin
        lights_ok = lights_one_hot(GRN, YLW, RED);
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        if (err_q || !lights_ok) begin
            state_d = ST_WAIT;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (EN) begin
                        if (RED) begin
                            state_d   = ST_COUNT;
                            cnt_load1 = 1'b1;
                        end else begin
                            cnt_clr = 1'b1;
                        end
                    end
                end
                ST_COUNT: begin
                    if (EN) begin
                        if (!RED) begin
                            state_d = ST_WAIT;
                            cnt_clr = 1'b1;
                        end else if (cnt_tc) begin
                            state_d = ST_FIRE;
                            cnt_clr = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                ST_FIRE: begin
                    // One cycle only, EN ignored; a still-lit RED re-arms straight into a new dwell.
                    if (RED) begin
                        state_d   = ST_COUNT;
                        cnt_load1 = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // State register; reset discards any partial dwell.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky lamp-fault flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (res) begin
            err_q <= 1'b0;
        end else if (!lights_ok) begin
            err_q <= 1'b1;
        end
    end

    // Outputs straight from registers so TIMEOUT is Moore and glitch-free.
    always_comb begin
        TIMEOUT = (state_q == ST_FIRE);
        ELAPSED = cnt_q;
        ERR     = err_q;
    end

endmodule

// File: tb/tb_semaforo_timeout_gen.sv
// tb/tb_semaforo_timeout_gen.sv - directed and random checks of semaforo_timeout_gen against a dwell model
module tb_semaforo_timeout_gen;

    localparam int RC = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          en  = 1'b1;
    logic          grn = 1'b0;
    logic          ylw = 1'b0;
    logic          red = 1'b0;
    logic          timeout;
    logic [CW-1:0] elapsed;
    logic          err;

    int total = 0;
    int bad   = 0;

    // Reference: number of enabled RED samples in the current run, pulse flag, sticky fault.
    int m_dwell = 0;
    bit m_pulse = 1'b0;
    bit m_err   = 1'b0;

    semaforo_timeout_gen #(
        .RED_CYCLES (RC),
        .CNT_W      (CW)
    ) dut (
        .clk     (clk),
        .res     (res),
        .EN      (en),
        .GRN     (grn),
        .YLW     (ylw),
        .RED     (red),
        .TIMEOUT (timeout),
        .ELAPSED (elapsed),
        .ERR     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model over that edge, compare after the edge.
    task automatic step(input string tag, input bit r_s, input bit e_s, input bit g, input bit y, input bit r);
        int n_lit;
        res = r_s; en = e_s; grn = g; ylw = y; red = r;
        @(posedge clk);
        n_lit = int'(g) + int'(y) + int'(r);
        if (r_s) begin
            m_dwell = 0; m_pulse = 0; m_err = 0;
        end else if (m_err || n_lit != 1) begin
            m_err = 1; m_dwell = 0; m_pulse = 0;
        end else if (m_pulse) begin
            m_pulse = 0;
            m_dwell = r ? 1 : 0;
        end else if (e_s) begin
            if (!r) begin
                m_dwell = 0;
            end else if (m_dwell + 1 == RC) begin
                m_dwell = 0; m_pulse = 1;
            end else begin
                m_dwell = m_dwell + 1;
            end
        end
        #1;
        chk({tag, ".timeout"}, 32'(timeout), 32'(m_pulse));
        chk({tag, ".elapsed"}, 32'(elapsed), 32'(m_dwell));
        chk({tag, ".err"},     32'(err),     32'(m_err));
    endtask

    initial begin : main
        int exp_el [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
        int exp_to [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
        int fl;
        int pulses;
        bit car;
        bit to_before;

        // 1: reset with RED lit, then release.
        #1;
        step("rst0", 1, 1, 0, 0, 1);
        step("rst1", 1, 1, 0, 0, 1);
        chk("rst.elapsed_const", 32'(elapsed), 0);
        chk("rst.timeout_const", 32'(timeout), 0);
        step("rel", 0, 1, 0, 0, 1);
        chk("rel.elapsed_const", 32'(elapsed), 1);

        // 2: fresh RED run from WAIT, held 10 edges -> pulses after e4 and e8.
        step("grn", 0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step("hold", 0, 1, 0, 0, 1);
            chk("hold.elapsed_const", 32'(elapsed), 32'(exp_el[i]));
            chk("hold.timeout_const", 32'(timeout), 32'(exp_to[i]));
        end

        // 3: RED drops at ELAPSED=2, then restarts at 1.
        step("d_grn", 0, 1, 1, 0, 0);
        step("d_r1", 0, 1, 0, 0, 1);
        step("d_r2", 0, 1, 0, 0, 1);
        step("d_drop", 0, 1, 0, 1, 0);
        chk("drop.elapsed_const", 32'(elapsed), 0);
        step("d_again", 0, 1, 0, 0, 1);

        // 4: EN=0 for three edges at ELAPSED=2 delays the pulse to e7.
        step("e_grn", 0, 1, 1, 0, 0);
        step("e_r1", 0, 1, 0, 0, 1);
        step("e_r2", 0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step("e_pause", 0, 0, 0, 0, 1);
            chk("pause.elapsed_const", 32'(elapsed), 2);
        end
        step("e_r3", 0, 1, 0, 0, 1);
        step("e_fire", 0, 1, 0, 0, 1);
        chk("pause.fire_const", 32'(timeout), 1);
        step("e_after", 0, 0, 0, 0, 1);

        // 5: GRN+RED together -> sticky ERR until reset.
        step("x_r1", 0, 1, 0, 0, 1);
        step("x_bad", 0, 1, 1, 0, 1);
        chk("err.set_const", 32'(err), 1);
        for (int i = 0; i < 6; i++) step("x_legal", 0, 1, 0, 0, 1);
        chk("err.sticky_const", 32'(err), 1);
        step("x_res", 1, 1, 0, 0, 1);
        chk("err.clear_const", 32'(err), 0);

        // 6: closed loop with a minimal FSM (0=GRN,1=YLW,2=RED).
        fl = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            to_before = timeout;
            car = (i == 2);
            step("loop", 0, 1, fl == 0, fl == 1, fl == 2);
            if (timeout) pulses++;
            if (fl == 0 && car)             fl = 1;
            else if (fl == 1)               fl = 2;
            else if (fl == 2 && to_before)  fl = 0;
        end
        chk("loop.pulses", 32'(pulses), 1);
        chk("loop.back_to_grn", 32'(fl), 0);
        chk("loop.err", 32'(err), 0);

        // Random traffic, mostly legal lamps, occasional faults and resets.
        for (int i = 0; i < 400; i++) begin
            int  pick;
            bit  rs;
            bit  e;
            logic [2:0] l;
            logic [2:0] bad_pat [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
            pick = int'($urandom_range(0, 49));
            rs   = ($urandom_range(0, 29) == 0);
            e    = ($urandom_range(0, 4) != 0);
            if (pick == 0)       l = bad_pat[$urandom_range(0, 4)];
            else if (pick < 32)  l = 3'b001;
            else if (pick < 42)  l = 3'b100;
            else                 l = 3'b010;
            step("rnd", rs, e, l[2], l[1], l[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
